// File: rtl/yc422_pkg.sv
// Shared types and defaults for the 4:4:4 -> 4:2:2 formatting stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package yc422_pkg;

  // Input-to-output latency of the formatter; the chroma pipe is built for exactly this depth.
  localparam int LAT_DEF = 3;

  // Video-range blanking levels: black luma, neutral chroma.
  localparam logic [7:0] BLANK_Y_DEF = 8'h10;
  localparam logic [7:0] BLANK_C_DEF = 8'h80;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } pix444_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/yc_chroma_pair.sv
// Pairs 4:4:4 chroma into alternating Cb/Cr samples; averages when YC422_CHROMA_AVG_EN is defined, else decimates.
// Latency: 2 cycles, i_* to o_* (outputs come straight from stage-2 registers).
// Backpressure: none; one pixel in and one pixel out every clock.
module yc_chroma_pair
  import yc422_pkg::*;
#(
  parameter logic [7:0] BLANK_Y  = BLANK_Y_DEF,
  parameter logic [7:0] BLANK_C  = BLANK_C_DEF,
  parameter bit         CB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_de,
  input  pix444_t    i_pix,
  output logic       o_de,
  output logic [7:0] o_y,
  output logic [7:0] o_c
);

  logic       r_phase;
  pix444_t    r_s1;
  logic       r_s1_de;
  logic       r_s1_ph;
  logic [7:0] r_s2_y;
  logic       r_s2_de;
  logic       r_s2_ph;
  logic [7:0] r_cb_pair;
  logic [7:0] r_cr_pair;

  logic       w_pair_ld;
  logic       w_sel_cr;
  logic [7:0] w_cb_nxt;
  logic [7:0] w_cr_nxt;

  // Phase of the pixel now at the input; cleared in blanking so every line starts on an even pixel.
  always_ff @(posedge clk) begin
    if (rst) r_phase <= 1'b0;
    else     r_phase <= i_de ? ~r_phase : 1'b0;
  end

  // Stage 1 holds the even pixel while its partner is at the input; stage 2 keeps only what the output mux needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= '{y: BLANK_Y, cb: BLANK_C, cr: BLANK_C};
      r_s1_de <= 1'b0;
      r_s1_ph <= 1'b0;
      r_s2_y  <= BLANK_Y;
      r_s2_de <= 1'b0;
      r_s2_ph <= 1'b0;
    end else begin
      r_s1    <= i_pix;
      r_s1_de <= i_de;
      r_s1_ph <= r_phase;
      r_s2_y  <= r_s1.y;
      r_s2_de <= r_s1_de;
      r_s2_ph <= r_s1_ph;
    end
  end

  // An even pixel in stage 1 always closes a pair: with its partner at the input, or alone at an odd line end.
  assign w_pair_ld = r_s1_de & ~r_s1_ph;

`ifdef YC422_CHROMA_AVG_EN
  // Rounded mean; the 9-bit sum cannot overflow.
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  // An unpaired last pixel keeps its own chroma.
  assign w_cb_nxt = i_de ? avg8(r_s1.cb, i_pix.cb) : r_s1.cb;
  assign w_cr_nxt = i_de ? avg8(r_s1.cr, i_pix.cr) : r_s1.cr;
`else
  // Decimation: the even pixel's chroma stands for the pair, and the odd pixel's chroma is dropped.
  assign w_cb_nxt = r_s1.cb;
  assign w_cr_nxt = r_s1.cr;
`endif

  // Pair registers hold across both output slots of the pair (stage-2 even and odd).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cb_pair <= BLANK_C;
      r_cr_pair <= BLANK_C;
    end else if (w_pair_ld) begin
      r_cb_pair <= w_cb_nxt;
      r_cr_pair <= w_cr_nxt;
    end
  end

  assign w_sel_cr = CB_FIRST ? r_s2_ph : ~r_s2_ph;
  assign o_c      = w_sel_cr ? r_cr_pair : r_cb_pair;
  assign o_y      = r_s2_y;
  assign o_de     = r_s2_de;

endmodule

// File: rtl/yc444_to_422.sv
// YCbCr 4:4:4 to 16-bit 4:2:2 {C,Y} formatter with aligned DE/HS/VS and line-length stats; YC422_CHROMA_AVG_EN selects chroma averaging.
// Latency: LAT (3) cycles on every output path.
// Backpressure: none; the stage runs at pixel rate.
module yc444_to_422
  import yc422_pkg::*;
#(
  parameter int         LAT      = LAT_DEF,  // only 3 matches the chroma pipe depth
  parameter logic [7:0] BLANK_Y  = BLANK_Y_DEF,
  parameter logic [7:0] BLANK_C  = BLANK_C_DEF,
  parameter bit         CB_FIRST = 1'b1,
  parameter int         LW       = 12
) (
  input  logic          sys2_clk,
  input  logic          sys2_rst,
  input  logic          in_de,
  input  logic          in_hs,
  input  logic          in_vs,
  input  logic [7:0]    in_y,
  input  logic [7:0]    in_cb,
  input  logic [7:0]    in_cr,
  output logic          out_de,
  output logic          out_hs,
  output logic          out_vs,
  output logic [15:0]   out_data,
  output logic [LW-1:0] line_len,
  output logic          odd_err,
  input  logic          odd_clr
);

  pix444_t     w_pix;
  logic        w_de;
  logic [7:0]  w_y;
  logic [7:0]  w_c;

  sync_t       r_sync [LAT];
  logic [15:0] r_data;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] r_line_len;
  logic        r_de_d;
  logic        r_odd_err;

  assign w_pix = '{y: in_y, cb: in_cb, cr: in_cr};

  yc_chroma_pair #(
    .BLANK_Y  (BLANK_Y),
    .BLANK_C  (BLANK_C),
    .CB_FIRST (CB_FIRST)
  ) u_pair (
    .clk   (sys2_clk),
    .rst   (sys2_rst),
    .i_de  (in_de),
    .i_pix (w_pix),
    .o_de  (w_de),
    .o_y   (w_y),
    .o_c   (w_c)
  );

  // Output word register; blanking is applied on the DE that travels with the pixel.
  always_ff @(posedge sys2_clk) begin
    if (sys2_rst) r_data <= {BLANK_C, BLANK_Y};
    else          r_data <= w_de ? {w_c, w_y} : {BLANK_C, BLANK_Y};
  end

  // Plain delay line for DE/HS/VS, LAT deep so sync lands with out_data.
  always_ff @(posedge sys2_clk) begin
    if (sys2_rst) begin
      for (int i = 0; i < LAT; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= '{de: in_de, hs: in_hs, vs: in_vs};
      for (int i = 1; i < LAT; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Saturating active-pixel counter; publishes on the DE falling edge, odd-set beats odd_clr.
  always_ff @(posedge sys2_clk) begin
    if (sys2_rst) begin
      r_cnt      <= '0;
      r_line_len <= '0;
      r_de_d     <= 1'b0;
      r_odd_err  <= 1'b0;
    end else begin
      r_de_d <= in_de;
      if (in_de) begin
        if (r_cnt != {LW{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end else if (r_de_d) begin
        r_line_len <= r_cnt;
        r_cnt      <= '0;
      end
      if (!in_de && r_de_d && r_cnt[0]) r_odd_err <= 1'b1;
      else if (odd_clr)                 r_odd_err <= 1'b0;
    end
  end

  assign out_de   = r_sync[LAT-1].de;
  assign out_hs   = r_sync[LAT-1].hs;
  assign out_vs   = r_sync[LAT-1].vs;
  assign out_data = r_data;
  assign line_len = r_line_len;
  assign odd_err  = r_odd_err;

endmodule

// File: tb/tb_yc444_to_422.sv
// Directed bench for yc444_to_422 with a per-cycle scoreboard on {de,hs,vs,data}.
module tb_yc444_to_422;

  logic        sys2_clk = 1'b0;
  logic        sys2_rst;
  logic        in_de, in_hs, in_vs, odd_clr;
  logic [7:0]  in_y, in_cb, in_cr;
  logic        out_de, out_hs, out_vs;
  logic [15:0] out_data;
  logic [11:0] line_len;
  logic        odd_err;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_pop  = 0;
  int de_cnt = 0;

  logic [18:0] sb[$];
  logic [7:0]  ly[4200];
  logic [7:0]  lcb[4200];
  logic [7:0]  lcr[4200];
  logic [15:0] dir_exp[4];

  yc444_to_422 dut (
    .sys2_clk (sys2_clk),
    .sys2_rst (sys2_rst),
    .in_de    (in_de),
    .in_hs    (in_hs),
    .in_vs    (in_vs),
    .in_y     (in_y),
    .in_cb    (in_cb),
    .in_cr    (in_cr),
    .out_de   (out_de),
    .out_hs   (out_hs),
    .out_vs   (out_vs),
    .out_data (out_data),
    .line_len (line_len),
    .odd_err  (odd_err),
    .odd_clr  (odd_clr)
  );

  always #5 sys2_clk = ~sys2_clk;

`ifdef YC422_CHROMA_AVG_EN
  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b) + 1;
    return 8'(s / 2);
  endfunction
`endif

  // Expected 16-bit word for active pixel i of an n-pixel line (CB_FIRST = 1).
  function automatic logic [15:0] model(input int i, input int n);
    logic [7:0] c;
    if (i % 2 == 0) begin
`ifdef YC422_CHROMA_AVG_EN
      c = (i + 1 < n) ? avg(lcb[i], lcb[i+1]) : lcb[i];
`else
      c = lcb[i];
`endif
    end else begin
`ifdef YC422_CHROMA_AVG_EN
      c = avg(lcr[i-1], lcr[i]);
`else
      c = lcr[i-1];
`endif
    end
    return {c, ly[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the current inputs, clock once, compare the word due now.
  task automatic tick(input logic [15:0] exp_d);
    logic [18:0] e, o;
    sb.push_back({in_de, in_hs, in_vs, (in_de ? exp_d : 16'h8010)});
    @(posedge sys2_clk);
    #1;
    if (out_de) de_cnt++;
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      o = {out_de, out_hs, out_vs, out_data};
      n_cmp++;
      n_pop++;
      assert (o === e) else begin
        n_bad++;
        $error("FAIL pipe#%0d observed=%h expected=%h", n_pop, o, e);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    sys2_rst = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge sys2_clk);
      #1;
      chk("rst_out", {13'd0, out_de, out_hs, out_vs, out_data}, {16'd0, 16'h8010});
      chk("rst_line_len", {20'd0, line_len}, 32'd0);
      chk("rst_odd_err", {31'd0, odd_err}, 32'd0);
      in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);
    end
    sys2_rst = 1'b0;
    sb.delete();
    sb.push_back({3'b000, 16'h8010});
    sb.push_back({3'b000, 16'h8010});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_de = 1'b0;
      in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);
      tick(16'h8010);
    end
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) begin
      in_de = 1'b1; in_y = ly[i]; in_cb = lcb[i]; in_cr = lcr[i];
      tick(model(i, n));
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      ly[i] = 8'($urandom); lcb[i] = 8'($urandom); lcr[i] = 8'($urandom);
    end
  endtask

  initial begin
    logic [15:0] hv;
`ifdef YC422_CHROMA_AVG_EN
    dir_exp = '{16'h0F01, 16'h3702, 16'h2303, 16'h4B04};
`else
    dir_exp = '{16'h0A01, 16'h3202, 16'h1E03, 16'h4604};
`endif
    odd_clr = 1'b0;
    in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b1;
    in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);

    // Reset with DE high and random pixels.
    do_reset(4);
    in_hs = 1'b0; in_vs = 1'b0;
    idle(3);

    // HS/VS toggled in blanking with 8'hFF pixels: pure 3-cycle delay, data stays blank.
    hv = 16'b00_01_11_11_10_10_00_01;
    for (int i = 0; i < 8; i++) begin
      in_de = 1'b0; in_y = 8'hFF; in_cb = 8'hFF; in_cr = 8'hFF;
      {in_hs, in_vs} = hv[2*i +: 2];
      tick(16'h8010);
    end
    in_hs = 1'b0; in_vs = 1'b0;
    idle(3);

    // Directed 4-pixel line with literal expected words.
    for (int i = 0; i < 4; i++) begin
      in_de = 1'b1; in_y = 8'(i + 1); in_cb = 8'(10 * (i + 1)); in_cr = 8'(50 + 10 * i);
      tick(dir_exp[i]);
    end
    idle(4);
    chk("len4", {20'd0, line_len}, 32'd4);
    chk("odd_err_len4", {31'd0, odd_err}, 32'd0);

    // 3-pixel line: last pixel uses its own Cb, odd_err rises at line end.
    ly[0] = 8'd5;   ly[1] = 8'd6;   ly[2] = 8'd7;
    lcb[0] = 8'd100; lcb[1] = 8'd110; lcb[2] = 8'd120;
    lcr[0] = 8'd200; lcr[1] = 8'd210; lcr[2] = 8'd220;
    line(3);
    idle(1);
    chk("odd_err_set3", {31'd0, odd_err}, 32'd1);
    idle(2);
    chk("len3", {20'd0, line_len}, 32'd3);
    odd_clr = 1'b1;
    idle(1);
    odd_clr = 1'b0;
    chk("odd_clr", {31'd0, odd_err}, 32'd0);

    // Odd line sets it again; odd_clr coincident with the next odd line end loses.
    fill_rand(5);
    line(5);
    idle(1);
    chk("odd_err_set5", {31'd0, odd_err}, 32'd1);
    fill_rand(7);
    line(7);
    odd_clr = 1'b1;
    idle(1);
    odd_clr = 1'b0;
    chk("set_wins", {31'd0, odd_err}, 32'd1);
    chk("len7", {20'd0, line_len}, 32'd7);
    idle(1);
    chk("odd_err_hold", {31'd0, odd_err}, 32'd1);
    odd_clr = 1'b1;
    idle(1);
    odd_clr = 1'b0;
    chk("odd_clr2", {31'd0, odd_err}, 32'd0);

    // Reset mid-line, then DE high on the first cycle after reset.
    fill_rand(10);
    for (int i = 0; i < 3; i++) begin
      in_de = 1'b1; in_y = ly[i]; in_cb = lcb[i]; in_cr = lcr[i];
      tick(model(i, 10));
    end
    do_reset(1);
    fill_rand(4);
    line(4);
    idle(4);
    chk("len_after_rst", {20'd0, line_len}, 32'd4);
    chk("odd_err_after_rst", {31'd0, odd_err}, 32'd0);

    // Over-long line saturates the counter.
    fill_rand(4100);
    line(4100);
    idle(3);
    chk("len_sat", {20'd0, line_len}, 32'd4095);
    odd_clr = 1'b1;
    idle(1);
    odd_clr = 1'b0;
    idle(4);

    // 1080p-width lines: 1920 active, 280 blank.
    de_cnt = 0;
    for (int l = 0; l < 3; l++) begin
      fill_rand(1920);
      line(1920);
      idle(280);
    end
    chk("len1920", {20'd0, line_len}, 32'd1920);
    chk("odd_err_1080", {31'd0, odd_err}, 32'd0);
    chk("de_count", de_cnt, 32'd5760);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
